// File: rtl/life_render_pkg.sv
// life_render_pkg: screen geometry, pixel/cursor types, population width and palette
package life_render_pkg;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    typedef logic [10:0] hcount_t;
    typedef logic [9:0]  vcount_t;
    typedef logic [10:0] pos_t;
    localparam int POP_WIDTH = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT + 1);
    typedef logic [POP_WIDTH-1:0] pop_t;
    typedef logic [11:0] rgb_t;
    localparam rgb_t RGB_BLACK        = 12'h000;
    localparam rgb_t RGB_ALIVE        = 12'hFFF;
    localparam rgb_t RGB_CURSOR_ALIVE = 12'hF80;
    localparam rgb_t RGB_CURSOR_DEAD  = 12'hF00;
    // Absolute difference taken one bit wider and signed, so a cursor near 0 never wraps
    function automatic logic [11:0] distance(input logic [10:0] a, input logic [10:0] b);
        logic signed [11:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d < 0 ? -d : d;
    endfunction
endpackage

// File: rtl/life_render_frame_stats.sv
// frame_stats: frame-start detection, blink frame counter and live-pixel population count
module frame_stats
    import life_render_pkg::*;
#(
    parameter int BLINK_LOG = 5
) (
    input  logic    clk,
    input  logic    rst_n,
    input  hcount_t hcount,
    input  vcount_t vcount,
    input  logic    live,
    output logic    blink_on,
    output pop_t    pop,
    output logic    pop_valid
);
    logic               at_origin, was_origin, frame_start, primed;
    logic [BLINK_LOG:0] frame_cnt;
    pop_t               pop_cnt;

    assign at_origin   = hcount == '0 && vcount == '0;
    assign frame_start = at_origin && !was_origin;
    assign blink_on    = ~frame_cnt[BLINK_LOG];

    // Count live pixels; publish only once a full frame has been seen since reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            was_origin <= 1'b0;
            primed     <= 1'b0;
            frame_cnt  <= '0;
            pop_cnt    <= '0;
            pop        <= '0;
            pop_valid  <= 1'b0;
        end else begin
            was_origin <= at_origin;
            pop_valid  <= frame_start && primed;
            if (frame_start) begin
                frame_cnt <= frame_cnt + 1'b1;
                primed    <= 1'b1;
                pop_cnt   <= POP_WIDTH'(live);
                if (primed) pop <= pop_cnt;
            end else begin
                pop_cnt <= pop_cnt + POP_WIDTH'(live);
            end
        end
    end
endmodule

// File: rtl/life_render.sv
// life_render: two-stage pixel pipeline colouring live cells and a blinking cursor box
module life_render
    import life_render_pkg::*;
#(
    parameter int CURSOR_R  = 2,
    parameter int BLINK_LOG = 5
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  hcount_t              hcount_in,
    input  vcount_t              vcount_in,
    input  logic                 alive_in,
    input  pos_t                 cursor_x_in,
    input  pos_t                 cursor_y_in,
    output hcount_t              hcount_out,
    output vcount_t              vcount_out,
    output logic [11:0]          rgb_out,
    output logic [POP_WIDTH-1:0] pop_out,
    output logic                 pop_valid_out
);
    logic        visible, s1_visible, s1_alive, blink_on, box;
    hcount_t     s1_hcount;
    vcount_t     s1_vcount;
    pos_t        s1_cursor_x, s1_cursor_y;
    logic [11:0] dist_h, dist_v, ring;
    rgb_t        colour;

    assign visible = hcount_in < hcount_t'(SCREEN_WIDTH) && vcount_in < vcount_t'(SCREEN_HEIGHT);

    frame_stats #(.BLINK_LOG(BLINK_LOG)) u_stats (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .hcount    (hcount_in),
        .vcount    (vcount_in),
        .live      (alive_in & visible),
        .blink_on  (blink_on),
        .pop       (pop_out),
        .pop_valid (pop_valid_out)
    );

    // Stage 1: capture pixel, visibility and the cursor position that applies to it
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_hcount   <= '0;
            s1_vcount   <= '0;
            s1_alive    <= 1'b0;
            s1_visible  <= 1'b0;
            s1_cursor_x <= '0;
            s1_cursor_y <= '0;
        end else begin
            s1_hcount   <= hcount_in;
            s1_vcount   <= vcount_in;
            s1_alive    <= alive_in;
            s1_visible  <= visible;
            s1_cursor_x <= cursor_x_in;
            s1_cursor_y <= cursor_y_in;
        end
    end

    // Chebyshev ring at exactly CURSOR_R marks the cursor box; blank overrides everything
    always_comb begin
        dist_h = distance(s1_hcount, s1_cursor_x);
        dist_v = distance({1'b0, s1_vcount}, s1_cursor_y);
        ring   = dist_h > dist_v ? dist_h : dist_v;
        box    = ring == 12'(CURSOR_R) && blink_on;
        colour = !s1_visible ? RGB_BLACK :
                 box         ? (s1_alive ? RGB_CURSOR_ALIVE : RGB_CURSOR_DEAD) :
                 s1_alive    ? RGB_ALIVE : RGB_BLACK;
    end

    // Stage 2: register colour with its coordinates so they stay aligned
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hcount_out <= '0;
            vcount_out <= '0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= s1_hcount;
            vcount_out <= s1_vcount;
            rgb_out    <= colour;
        end
    end
endmodule

// File: doc/life_render.md
LIFE_RENDER -- requirements
Module: life_render

Interface
REQ-001 SHALL have parameter CURSOR_R, default 2, meaning cursor box half-width in pixels.
REQ-002 SHALL have parameter BLINK_LOG, default 5, meaning the cursor is visible for 2^BLINK_LOG frames, then hidden for 2^BLINK_LOG frames.
REQ-003 SHALL have port clk_in, input, 1 bit: the single system clock; every register is rising-edge.
REQ-004 SHALL have port rst_n_in, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port hcount_in, input, hcount_t: pixel column from life_logic hcount_out.
REQ-006 SHALL have port vcount_in, input, vcount_t: pixel row from life_logic vcount_out.
REQ-007 SHALL have port alive_in, input, 1 bit: cell state from life_logic alive_out, aligned with hcount_in/vcount_in.
REQ-008 SHALL have ports cursor_x_in and cursor_y_in, input, pos_t each: cursor position.
REQ-009 SHALL have ports hcount_out (hcount_t) and vcount_out (vcount_t), output: the coordinates delayed to match rgb_out.
REQ-010 SHALL have port rgb_out, output, 12 bits: 4:4:4 pixel colour.
REQ-011 SHALL have port pop_out, output, POP_WIDTH bits: live-pixel count of the last complete frame.
REQ-012 SHALL have port pop_valid_out, output, 1 bit: one-cycle strobe when pop_out updates.

Function
REQ-013 SHALL be a 2-stage pipeline: the input presented at edge N appears on hcount_out, vcount_out and rgb_out after edge N+2; throughput is one pixel per cycle, with no stall.
REQ-014 SHALL treat a pixel as visible iff hcount_in < SCREEN_WIDTH and vcount_in < SCREEN_HEIGHT; a non-visible pixel SHALL output rgb 12'h000.
REQ-015 SHALL mark a pixel as cursor-box when max(|h-cx|, |v-cy|) == CURSOR_R.
- The subtraction SHALL be computed at width+1 signed, so there is no unsigned wrap.
- When the cursor is at 0 or at the screen edge, the box SHALL be clipped, not wrapped.
REQ-016 SHALL apply colour priority as follows:
- blank -> 12'h000
- cursor-box and blink-on, alive -> 12'hF80
- cursor-box and blink-on, dead -> 12'hF00
- alive -> 12'hFFF
- otherwise -> 12'h000
REQ-017 SHALL define frame start as the input cycle with hcount_in == 0 and vcount_in == 0; it SHALL be detected once per frame, edge-qualified against the previous cycle.
REQ-018 SHALL keep a frame_cnt of BLINK_LOG+1 bits that increments at each frame start and wraps modulo 2^(BLINK_LOG+1); blink-on SHALL equal ~frame_cnt[BLINK_LOG].
REQ-019 SHALL keep a pop counter that increments on each visible input pixel with alive_in = 1.
- At frame start, the counter SHALL be latched into pop_out, pop_valid_out SHALL pulse for 1 cycle, and the counter SHALL reload to (alive_in & visible) of that same pixel.
REQ-020 SHALL size POP_WIDTH = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT+1) so the counter cannot overflow.
REQ-021 SHALL sample the cursor inputs in stage 1 together with the pixel; a cursor change SHALL take effect on the next pixel, with no frame-boundary hold.

Reset
REQ-022 SHALL, while rst_n_in = 0, asynchronously force the following:
- hcount_out = 0, vcount_out = 0, rgb_out = 12'h000
- pop_out = 0, pop_valid_out = 0
- frame_cnt = 0, pop counter = 0
- all pipeline valid/data registers cleared
REQ-023 SHALL, after reset deassertion mid-frame, withhold pop_valid_out until the second frame start, because the first count is partial.

Structure
REQ-024 SHALL take hcount_t, vcount_t, pos_t, SCREEN_WIDTH and SCREEN_HEIGHT from common.svh; POP_WIDTH and the colour constants SHALL be added there.
REQ-025 SHALL place frame-start detection, frame_cnt and the pop counter in sub-module frame_stats; the pipeline and colour mux SHALL remain in life_render.

Verification
REQ-026 SHALL verify reset: assert rst_n_in = 0 mid-stream -> all outputs read 0 immediately, without waiting for a clock edge.
REQ-027 SHALL verify latency and colour: alive_in = 1 at (10,10), cursor at (100,100) -> rgb_out = 12'hFFF exactly 2 cycles later, with hcount_out = 10 and vcount_out = 10.
REQ-028 SHALL verify cursor clipping: cursor at (0,0), all dead, frame_cnt = 0 -> the following colours appear:
- 12'hF00 at (2,0), (0,2) and (2,2)
- 12'h000 at (1,1)
- no red pixels near hcount = SCREEN_WIDTH-2 (no wrap)
REQ-029 SHALL verify the blink: run 2^BLINK_LOG = 32 frames -> the cursor is absent in frames 32-63 and reappears in frame 64.
REQ-030 SHALL verify population counting: drive alive_in = 1 on exactly 37 visible pixels plus several blank pixels -> pop_out = 37 with a single pop_valid_out pulse at the next frame start.
REQ-031 SHALL verify reset mid-frame followed by two frames: no pop_valid_out at the first frame start; valid at the second.
